// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory stage of the pipeline. It takes the M-stage signals from the EX/MEM
//   register, performs a single-outstanding data-memory access, formats load
//   data and registers the results into the MEM/WB register.
//
// Ports
//   CLK, RST                  clock (rising edge), async active-low reset
//   ALURESULTM .. Funct3M     M-stage inputs (address/ALU result, result
//                             select, store/regwrite controls, store data,
//                             Rd, PC+4, access size/sign)
//   DMemReq/We/Addr/WData/BE  request to data memory (held while pending)
//   DMemReady, DMemRData      completion strobe and raw read word
//   StallM                    access pending, freeze upstream stages
//   *W, MisalignW             MEM/WB register outputs
module mem_access_stage #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] ALURESULTM,
   input  logic [1:0]       ResultSrcM,
   input  logic             MemWriteM,
   input  logic             RegWriteM,
   input  logic [WIDTH-1:0] WriteDataM,
   input  logic [4:0]       RdM,
   input  logic [WIDTH-1:0] PCPlus4M,
   input  logic [2:0]       Funct3M,
   output logic             DMemReq,
   output logic             DMemWe,
   output logic [WIDTH-1:0] DMemAddr,
   output logic [WIDTH-1:0] DMemWData,
   output logic [3:0]       DMemBE,
   input  logic             DMemReady,
   input  logic [WIDTH-1:0] DMemRData,
   output logic             StallM,
   output logic [WIDTH-1:0] ALURESULTW,
   output logic [WIDTH-1:0] ReadDataW,
   output logic [1:0]       ResultSrcW,
   output logic             RegWriteW,
   output logic [4:0]       RdW,
   output logic [WIDTH-1:0] PCPlus4W,
   output logic             MisalignW
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] alu_q, alu_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]       rsrc_q, rsrc_d;
   logic             rw_q, rw_d;
   logic [4:0]       rd_q, rd_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             mis_q, mis_d;

   logic             is_load, mem_op, sz_byte, sz_half, sz_word;
   logic             misalign, access, req, stall;
   logic             sext;
   logic [1:0]       off;
   logic [WIDTH-1:0] shifted, ld_fmt;

   assign off     = ALURESULTM[1:0];
   assign is_load = (ResultSrcM == 2'b01);
   assign mem_op  = MemWriteM | is_load;

   // Unsigned variants only exist for loads; any other funct3 falls back to word.
   assign sz_byte = (Funct3M == 3'b000) | (is_load & (Funct3M == 3'b100));
   assign sz_half = (Funct3M == 3'b001) | (is_load & (Funct3M == 3'b101));
   assign sz_word = ~sz_byte & ~sz_half;

   assign misalign = mem_op & ((sz_half & off[0]) | (sz_word & (off != 2'b00)));
   assign access   = mem_op & ~misalign;

   // Gated by RST so an abandoned access drops the request while reset is low.
   assign req     = RST & ((state_q == WAIT) | access);
   assign stall   = req & ~DMemReady;

   assign DMemReq  = req;
   assign StallM   = stall;
   assign DMemWe   = req & MemWriteM;
   assign DMemAddr = {ALURESULTM[WIDTH-1:2], 2'b00};

   always_comb begin
      DMemBE    = 4'b0000;
      DMemWData = WriteDataM;
      if (req) begin
         if (!MemWriteM)   DMemBE = 4'b1111;
         else if (sz_byte) DMemBE = 4'b0001 << off;
         else if (sz_half) DMemBE = 4'b0011 << off;
         else              DMemBE = 4'b1111;
      end
      if (sz_byte)      DMemWData = {4{WriteDataM[7:0]}};
      else if (sz_half) DMemWData = {2{WriteDataM[15:0]}};
   end

   // Bring the addressed lane down to bit 0, then extend.
   assign sext    = ~Funct3M[2];
   assign shifted = DMemRData >> {off, 3'b000};

   always_comb begin
      if (sz_byte)      ld_fmt = {{(WIDTH-8){sext & shifted[7]}}, shifted[7:0]};
      else if (sz_half) ld_fmt = {{(WIDTH-16){sext & shifted[15]}}, shifted[15:0]};
      else              ld_fmt = DMemRData;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (access && !DMemReady) state_d = WAIT;
         WAIT:    if (DMemReady)            state_d = IDLE;
         default: state_d = IDLE;
      endcase

      alu_d   = '0;
      rdata_d = '0;
      rsrc_d  = 2'b00;
      rw_d    = 1'b0;
      rd_d    = '0;
      pc_d    = '0;
      mis_d   = 1'b0;
      if (!stall) begin
         alu_d   = ALURESULTM;
         rsrc_d  = ResultSrcM;
         rw_d    = RegWriteM & ~misalign;
         rd_d    = RdM;
         pc_d    = PCPlus4M;
         mis_d   = misalign;
         rdata_d = (is_load && !misalign) ? ld_fmt : '0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         alu_q   <= '0;
         rdata_q <= '0;
         rsrc_q  <= 2'b00;
         rw_q    <= 1'b0;
         rd_q    <= '0;
         pc_q    <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         alu_q   <= alu_d;
         rdata_q <= rdata_d;
         rsrc_q  <= rsrc_d;
         rw_q    <= rw_d;
         rd_q    <= rd_d;
         pc_q    <= pc_d;
         mis_q   <= mis_d;
      end
   end

   assign ALURESULTW = alu_q;
   assign ReadDataW  = rdata_q;
   assign ResultSrcW = rsrc_q;
   assign RegWriteW  = rw_q;
   assign RdW        = rd_q;
   assign PCPlus4W   = pc_q;
   assign MisalignW  = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] ALURESULTM = '0;
   logic [1:0]  ResultSrcM = '0;
   logic        MemWriteM = 1'b0;
   logic        RegWriteM = 1'b0;
   logic [31:0] WriteDataM = '0;
   logic [4:0]  RdM = '0;
   logic [31:0] PCPlus4M = '0;
   logic [2:0]  Funct3M = '0;
   logic        DMemReq, DMemWe;
   logic [31:0] DMemAddr, DMemWData;
   logic [3:0]  DMemBE;
   logic        DMemReady = 1'b0;
   logic [31:0] DMemRData = '0;
   logic        StallM;
   logic [31:0] ALURESULTW, ReadDataW, PCPlus4W;
   logic [1:0]  ResultSrcW;
   logic        RegWriteW, MisalignW;
   logic [4:0]  RdW;

   int errs = 0;
   int checks = 0;

   mem_access_stage #(.WIDTH(32)) dut (
      .CLK(CLK), .RST(RST),
      .ALURESULTM(ALURESULTM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
      .RegWriteM(RegWriteM), .WriteDataM(WriteDataM), .RdM(RdM),
      .PCPlus4M(PCPlus4M), .Funct3M(Funct3M),
      .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
      .DMemWData(DMemWData), .DMemBE(DMemBE), .DMemReady(DMemReady),
      .DMemRData(DMemRData), .StallM(StallM),
      .ALURESULTW(ALURESULTW), .ReadDataW(ReadDataW), .ResultSrcW(ResultSrcW),
      .RegWriteW(RegWriteW), .RdW(RdW), .PCPlus4W(PCPlus4W), .MisalignW(MisalignW)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Access size in bytes from funct3; unsigned forms exist only for loads.
   function automatic int size_of(input logic [2:0] f3, input bit ld);
      if (f3 == 3'd0 || (ld && f3 == 3'd4)) return 1;
      if (f3 == 3'd1 || (ld && f3 == 3'd5)) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] load_val(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [31:0] addr);
      int unsigned sz, off;
      longint unsigned v, lim;
      sz  = size_of(f3, 1'b1);
      off = addr % 4;
      if (sz == 4) return word;
      lim = 64'd1 << (8 * sz);
      v   = (longint'(word) / (64'd1 << (8 * off))) % lim;
      if (f3[2] == 1'b0 && v >= lim / 2) v = v + (64'h1_0000_0000 - lim);
      return v[31:0];
   endfunction

   task automatic do_op(input logic [1:0] rs, input logic mw, input logic rw,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] rdata,
                        input int nwait);
      bit ld, memop, mis, acc;
      int sz;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      ld    = (rs == 2'b01);
      memop = mw || ld;
      sz    = size_of(f3, ld);
      mis   = memop && (addr % sz != 0);
      acc   = memop && !mis;
      if (!mw) e_be = 4'hF;
      else     e_be = 4'(((1 << sz) - 1) << (addr % 4));
      if (sz == 1)      e_wd = {24'd0, wd[7:0]} * 32'h0101_0101;
      else if (sz == 2) e_wd = {16'd0, wd[15:0]} * 32'h0001_0001;
      else              e_wd = wd;

      ALURESULTM = addr; ResultSrcM = rs; MemWriteM = mw; RegWriteM = rw;
      Funct3M = f3; WriteDataM = wd; RdM = rd; PCPlus4M = pc;

      if (acc) begin
         for (int i = 0; i < nwait; i++) begin
            DMemReady = 1'b0;
            DMemRData = $urandom;
            #3;
            chk("wait_req", 32'(DMemReq), 32'd1);
            chk("wait_stall", 32'(StallM), 32'd1);
            chk("wait_addr", DMemAddr, addr & ~32'd3);
            chk("wait_be", 32'(DMemBE), 32'(e_be));
            chk("wait_we", 32'(DMemWe), 32'(mw));
            if (mw) chk("wait_wdata", DMemWData, e_wd);
            @(posedge CLK); #1;
            chk("bubble_rw", 32'(RegWriteW), 32'd0);
            chk("bubble_rsrc", 32'(ResultSrcW), 32'd0);
            chk("bubble_mis", 32'(MisalignW), 32'd0);
            chk("bubble_alu", ALURESULTW, 32'd0);
         end
      end

      DMemReady = acc ? 1'b1 : 1'($urandom);
      DMemRData = rdata;
      #3;
      chk("req", 32'(DMemReq), 32'(acc));
      chk("stall", 32'(StallM), 32'd0);
      if (acc) begin
         chk("addr", DMemAddr, addr & ~32'd3);
         chk("be", 32'(DMemBE), 32'(e_be));
         chk("we", 32'(DMemWe), 32'(mw));
         if (mw) chk("wdata", DMemWData, e_wd);
      end
      @(posedge CLK); #1;
      DMemReady = 1'b0;
      chk("alu_w", ALURESULTW, addr);
      chk("rsrc_w", 32'(ResultSrcW), 32'(rs));
      chk("rw_w", 32'(RegWriteW), 32'(rw && !mis));
      chk("rd_w", 32'(RdW), 32'(rd));
      chk("pc_w", PCPlus4W, pc);
      chk("mis_w", 32'(MisalignW), 32'(mis));
      chk("rdata_w", ReadDataW, (ld && !mis) ? load_val(rdata, f3, addr) : 32'd0);
   endtask

   initial begin
      logic [1:0]  rs;
      logic        mw;
      logic [31:0] a;
      int          k;

      #3;
      chk("rst_req", 32'(DMemReq), 32'd0);
      chk("rst_stall", 32'(StallM), 32'd0);
      chk("rst_rw", 32'(RegWriteW), 32'd0);
      chk("rst_alu", ALURESULTW, 32'd0);
      chk("rst_mis", 32'(MisalignW), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;

      // ALU op, zero-wait LB, 3-wait LHU, SB, misaligned LW
      do_op(2'b00, 1'b0, 1'b1, 3'd0, 32'h1234, 32'h0, 5'd5, 32'h40, 32'h0, 0);
      do_op(2'b01, 1'b0, 1'b1, 3'd0, 32'h103, 32'h0, 5'd6, 32'h44, 32'h80FF_0000, 0);
      chk("lb_val", ReadDataW, 32'hFFFF_FF80);
      do_op(2'b01, 1'b0, 1'b1, 3'd5, 32'h102, 32'h0, 5'd7, 32'h48, 32'hBEEF_0000, 3);
      chk("lhu_val", ReadDataW, 32'h0000_BEEF);
      do_op(2'b00, 1'b1, 1'b0, 3'd0, 32'h201, 32'h0000_00AB, 5'd0, 32'h4C, 32'h0, 1);
      do_op(2'b01, 1'b0, 1'b1, 3'd2, 32'h102, 32'h0, 5'd8, 32'h50, 32'h0, 0);

      // Reset while waiting on an aligned LW
      ALURESULTM = 32'h300; ResultSrcM = 2'b01; MemWriteM = 1'b0; RegWriteM = 1'b1;
      Funct3M = 3'd2; RdM = 5'd9; DMemReady = 1'b0;
      #3;
      chk("pre_rst_stall", 32'(StallM), 32'd1);
      @(posedge CLK); #1;
      RST = 1'b0;
      #1;
      chk("rstw_req", 32'(DMemReq), 32'd0);
      chk("rstw_stall", 32'(StallM), 32'd0);
      chk("rstw_rw", 32'(RegWriteW), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b1;
      do_op(2'b00, 1'b0, 1'b1, 3'd0, 32'hCAFE, 32'h0, 5'd3, 32'h60, 32'h0, 0);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 3);
         rs = (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : (k == 2) ? 2'b01 : 2'b00;
         mw = (k == 3);
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         do_op(rs, mw, 1'($urandom), 3'($urandom), a, $urandom, 5'($urandom),
               $urandom, $urandom, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer end of the EX/MEM pipeline register: takes the M-stage signals and performs the data-memory access.
- Drives a single-outstanding req/ready handshake to an external data memory.
- Formats load data (byte/half/word, signed or unsigned) and registers results into the MEM/WB pipeline register.
- Raises StallM so the hazard unit freezes upstream stages while an access is pending.

Parameters:
- WIDTH, 32, datapath and address width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- ALURESULTM  in  WIDTH  effective address, or ALU result for non-memory ops.
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4.
- MemWriteM  in  1  store.
- RegWriteM  in  1  writes Rd.
- WriteDataM  in  WIDTH  store data.
- RdM  in  5  destination register.
- PCPlus4M  in  WIDTH  PC+4.
- Funct3M  in  3  access size/sign (RV32I load/store funct3).
- DMemReq  out  1  access request.
- DMemWe  out  1  1 store, 0 load.
- DMemAddr  out  WIDTH  word-aligned address ({ALURESULTM[WIDTH-1:2],2'b00}).
- DMemWData  out  WIDTH  lane-replicated store data.
- DMemBE  out  4  byte enables.
- DMemReady  in  1  access complete; for loads, DMemRData valid this cycle.
- DMemRData  in  WIDTH  raw read word.
- StallM  out  1  access pending, hold upstream.
- ALURESULTW  out  WIDTH  MEM/WB ALU result.
- ReadDataW  out  WIDTH  formatted load data.
- ResultSrcW  out  2  MEM/WB result select.
- RegWriteW  out  1  MEM/WB register write.
- RdW  out  5  MEM/WB destination.
- PCPlus4W  out  WIDTH  MEM/WB PC+4.
- MisalignW  out  1  one-cycle flag: instruction in WB was a misaligned access, suppressed.

Behaviour:
- Reset (async, RST low): state IDLE; all W outputs, MisalignW, DMemReq and StallM are 0 immediately.
- Memory op: MemOp = MemWriteM | (ResultSrcM==01).
- Misaligned:
  - halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No request is issued.
  - Single-cycle pass with RegWriteW=0 and MisalignW=1.
- FSM states: IDLE, WAIT.
  - IDLE, aligned MemOp:
    - DMemReq=1 combinationally.
    - If DMemReady the same cycle, the access completes (0 wait states).
    - Otherwise StallM=1 and go to WAIT.
  - IDLE, non-MemOp: StallM=0; the MEM/WB register captures the inputs next edge (1-cycle latency); DMemReady is ignored.
  - WAIT:
    - DMemReq=1 and StallM=1.
    - Address, data and BE are held stable; the M inputs are guaranteed stable by the upstream freeze.
    - On DMemReady: complete, StallM=0 that cycle, go to IDLE.
- On completion: MEM/WB captures ALURESULTM, ResultSrcM, RegWriteM, RdM, PCPlus4M, plus formatted ReadDataW (loads), at the next edge.
- On any stalled cycle: MEM/WB loads a bubble (RegWriteW=0, ResultSrcW=00, MisalignW=0, other fields 0).
- Store lanes:
  - SB: BE = 0001 << addr[1:0], data = byte replicated ×4.
  - SH: BE = 0011 << addr[1:0], data = half replicated ×2.
  - SW: BE = 1111.
- Loads: DMemBE=1111, DMemWe=0.
  - LB/LH/LW select the lane by addr[1:0] and sign-extend.
  - LBU/LHU zero-extend.
- Invalid Funct3: treated as word.
- Reset while in WAIT: request dropped, state IDLE, the access is abandoned.

Test Plan:
- ALU op (ResultSrcM=00, RegWriteM=1, ALURESULTM=0x1234, RdM=5) → next edge: ALURESULTW=0x1234, RdW=5, RegWriteW=1, DMemReq never high.
- LB, addr 0x103, DMemReady same cycle, DMemRData=0x80FF_0000 → no stall, ReadDataW=0xFFFF_FF80.
- LHU, addr 0x102, DMemReady after 3 cycles, DMemRData=0xBEEF_0000 → StallM high for 3 cycles with bubbles (RegWriteW=0), then ReadDataW=0x0000_BEEF.
- SB, addr 0x201, WriteDataM=0x0000_00AB → DMemAddr=0x200, DMemBE=0010, DMemWData=0xABAB_ABAB, DMemWe=1.
- LW at 0x102 → DMemReq stays 0, RegWriteW=0, MisalignW=1 for one cycle.
- RST low during WAIT → DMemReq and StallM fall immediately; after release, an ALU op passes in 1 cycle.
